// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared types and constants for the trex collision checker.
//   coll_state_t : scan controller states (IDLE -> SCAN -> DRAIN -> IDLE)
//   box_t        : axis-aligned box {x, y, w, h} in screen pixels
//   shrink_size  : trims a box dimension by a total amount, clamping at zero
// -----------------------------------------------------------------------------
package collision_pkg;

  // Coordinate width of the trex position ports and of every box field.
  localparam int COORD_W_DEF = 10;

  // Pixels trimmed from each side of the trex box, so near misses stay alive.
  localparam int MARGIN_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } coll_state_t;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [COORD_W_DEF-1:0] w;
    logic [COORD_W_DEF-1:0] h;
  } box_t;

  // A dimension no larger than the total trim collapses to an empty box
  // instead of wrapping to a huge unsigned size.
  function automatic logic [COORD_W_DEF-1:0] shrink_size(
    input logic [COORD_W_DEF-1:0] size,
    input logic [COORD_W_DEF-1:0] trim
  );
    shrink_size = (size > trim) ? (size - trim) : '0;
  endfunction

endpackage : collision_pkg

// File: rtl/aabb_overlap.sv
// -----------------------------------------------------------------------------
// aabb_overlap
// Combinational axis-aligned bounding box overlap test.
// Ports:
//   i_a, i_b : the two boxes to test
//   o_hit    : 1 when the boxes share interior area
// Edges that only touch do not count as a hit, and a box with zero width or
// zero height never hits. Far edges are summed one bit wider than the
// coordinates so boxes near the right or bottom of the field cannot wrap.
// -----------------------------------------------------------------------------
module aabb_overlap
  import collision_pkg::*;
(
  input  box_t i_a,
  input  box_t i_b,
  output logic o_hit
);

  localparam int CW = COORD_W_DEF;

  logic [CW:0] w_a_x0;
  logic [CW:0] w_a_y0;
  logic [CW:0] w_b_x0;
  logic [CW:0] w_b_y0;
  logic [CW:0] w_a_x1;
  logic [CW:0] w_a_y1;
  logic [CW:0] w_b_x1;
  logic [CW:0] w_b_y1;
  logic        w_a_solid;
  logic        w_b_solid;
  logic        w_x_overlap;
  logic        w_y_overlap;

  assign w_a_x0 = {1'b0, i_a.x};
  assign w_a_y0 = {1'b0, i_a.y};
  assign w_b_x0 = {1'b0, i_b.x};
  assign w_b_y0 = {1'b0, i_b.y};

  assign w_a_x1 = {1'b0, i_a.x} + {1'b0, i_a.w};
  assign w_a_y1 = {1'b0, i_a.y} + {1'b0, i_a.h};
  assign w_b_x1 = {1'b0, i_b.x} + {1'b0, i_b.w};
  assign w_b_y1 = {1'b0, i_b.y} + {1'b0, i_b.h};

  assign w_a_solid = (i_a.w != '0) && (i_a.h != '0);
  assign w_b_solid = (i_b.w != '0) && (i_b.h != '0);

  // Strict comparisons: a shared edge is not an overlap.
  assign w_x_overlap = (w_a_x0 < w_b_x1) && (w_b_x0 < w_a_x1);
  assign w_y_overlap = (w_a_y0 < w_b_y1) && (w_b_y0 < w_a_y1);

  assign o_hit = w_a_solid && w_b_solid && w_x_overlap && w_y_overlap;

endmodule : aabb_overlap

// File: rtl/trex_collision.sv
// -----------------------------------------------------------------------------
// trex_collision
// On each game update tick, snapshots the trex box (shrunk by MARGIN on every
// side) and scans the obstacle slot table one slot per cycle through a
// 1-cycle-latency read port. The first overlapping valid slot sets a sticky
// crash flag and records its index.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   update              game tick pulse
//   enable              scans only start while high
//   restart             clears crash/hit_idx and aborts any scan
//   trex_x/y/w/h        trex box, sampled only when a scan starts
//   obs_rd_idx          slot index requested (registered)
//   obs_valid, obs_x/y/w/h
//                       slot data for the index requested one cycle earlier
//   crash               sticky hit flag
//   hit_idx             first slot that hit in the scan that set crash
//   done                1-cycle pulse when a scan completes
//   overrun             1-cycle pulse when an update arrives mid-scan
// Timing: a scan started at edge E0 raises done in the cycle after E0+N_OBS+1.
// -----------------------------------------------------------------------------
module trex_collision
  import collision_pkg::*;
#(
  parameter int N_OBS   = 4,
  parameter int IDX_W   = (N_OBS > 1) ? $clog2(N_OBS) : 1,
  // box_t fields are COORD_W_DEF wide; COORD_W must stay equal to it.
  parameter int COORD_W = COORD_W_DEF,
  parameter int MARGIN  = MARGIN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic               enable,
  input  logic               restart,
  input  logic [COORD_W-1:0] trex_x,
  input  logic [COORD_W-1:0] trex_y,
  input  logic [COORD_W-1:0] trex_w,
  input  logic [COORD_W-1:0] trex_h,
  output logic [IDX_W-1:0]   obs_rd_idx,
  input  logic               obs_valid,
  input  logic [COORD_W-1:0] obs_x,
  input  logic [COORD_W-1:0] obs_y,
  input  logic [COORD_W-1:0] obs_w,
  input  logic [COORD_W-1:0] obs_h,
  output logic               crash,
  output logic [IDX_W-1:0]   hit_idx,
  output logic               done,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] MARGIN_OFF = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] SIZE_TRIM  = COORD_W'(2 * MARGIN);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_OBS - 1);

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  coll_state_t      r_state;
  coll_state_t      w_next_state;

  box_t             r_box;       // shrunk trex box captured at scan start
  logic [IDX_W-1:0] r_rd_idx;    // slot index currently presented to the table
  logic             r_cmp_v;     // obstacle inputs this cycle belong to a scan
  logic [IDX_W-1:0] r_cmp_slot;  // slot number of the data being compared
  logic             r_crash;
  logic [IDX_W-1:0] r_hit_idx;
  logic             r_done;
  logic             r_overrun;

  logic             w_start;
  logic             w_last_issue;
  logic             w_overlap;
  logic             w_slot_hit;
  box_t             w_obs_box;
  box_t             w_snap_box;

  assign w_start      = (r_state == IDLE) && update && enable;
  assign w_last_issue = (r_state == SCAN) && (r_rd_idx == LAST_IDX);

  assign w_snap_box = '{
    x: trex_x + MARGIN_OFF,
    y: trex_y + MARGIN_OFF,
    w: shrink_size(trex_w, SIZE_TRIM),
    h: shrink_size(trex_h, SIZE_TRIM)
  };

  assign w_obs_box = '{x: obs_x, y: obs_y, w: obs_w, h: obs_h};

  // ---------------------------------------------------------------------------
  // Overlap test against the slot returned by the read port
  // ---------------------------------------------------------------------------
  aabb_overlap u_overlap (
    .i_a   (r_box),
    .i_b   (w_obs_box),
    .o_hit (w_overlap)
  );

  assign w_slot_hit = r_cmp_v && obs_valid && w_overlap;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment uses <= so all registers sample the same
    // pre-edge values; a blocking = here would leak new values into later
    // statements of the same edge.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves the output
    // unassigned, which would infer a latch.
    w_next_state = r_state;
    if (restart) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (update && enable) w_next_state = SCAN;
        SCAN:    if (w_last_issue)     w_next_state = DRAIN;
        DRAIN:                         w_next_state = IDLE;
        default:                       w_next_state = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control path: read index, compare-valid, sticky result, pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_idx  <= '0;
      r_cmp_v   <= 1'b0;
      r_crash   <= 1'b0;
      r_hit_idx <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (restart) begin
      // Abort outright: a same-cycle hit, update or scan end is discarded.
      r_rd_idx  <= '0;
      r_cmp_v   <= 1'b0;
      r_crash   <= 1'b0;
      r_hit_idx <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // DRAIN always lasts exactly one cycle, so its exit edge is now.
      r_done    <= (r_state == DRAIN);
      r_overrun <= update && (r_state != IDLE);

      // Every index issued in SCAN returns data on the following cycle.
      r_cmp_v   <= (r_state == SCAN);

      if (w_start) begin
        r_rd_idx <= '0;
      end else if (r_state == SCAN) begin
        // Park at slot 0 after the last issue so the port idles there.
        r_rd_idx <= w_last_issue ? '0 : (r_rd_idx + 1'b1);
      end

      // Only the first hit since the last clear is recorded.
      if (w_slot_hit && !r_crash) begin
        r_crash   <= 1'b1;
        r_hit_idx <= r_cmp_slot;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data path: snapshot box and the slot-number pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: these hold data only, never control; every consumer is qualified
    // by r_cmp_v or by entering SCAN, so they are left without reset.
    if (w_start && !restart) begin
      r_box <= w_snap_box;
    end
    r_cmp_slot <= r_rd_idx;
  end

  assign obs_rd_idx = r_rd_idx;
  assign crash      = r_crash;
  assign hit_idx    = r_hit_idx;
  assign done       = r_done;
  assign overrun    = r_overrun;

endmodule : trex_collision

// File: tb/tb_trex_collision.sv
// -----------------------------------------------------------------------------
// tb_trex_collision
// Directed bench for trex_collision. Each scan request pushes the expected
// {crash, hit_idx, done cycle} into a queue; a monitor pops one entry on every
// done pulse. A behavioural slot table answers obs_rd_idx one cycle later.
// -----------------------------------------------------------------------------
module tb_trex_collision;

  logic       clk = 1'b0;
  logic       rst;
  logic       update;
  logic       enable;
  logic       restart;
  logic [9:0] trex_x, trex_y, trex_w, trex_h;
  logic [1:0] obs_rd_idx;
  logic       obs_valid;
  logic [9:0] obs_x, obs_y, obs_w, obs_h;
  logic       crash;
  logic [1:0] hit_idx;
  logic       done;
  logic       overrun;

  always #5 clk = ~clk;

  trex_collision dut (
    .clk        (clk),
    .rst        (rst),
    .update     (update),
    .enable     (enable),
    .restart    (restart),
    .trex_x     (trex_x),
    .trex_y     (trex_y),
    .trex_w     (trex_w),
    .trex_h     (trex_h),
    .obs_rd_idx (obs_rd_idx),
    .obs_valid  (obs_valid),
    .obs_x      (obs_x),
    .obs_y      (obs_y),
    .obs_w      (obs_w),
    .obs_h      (obs_h),
    .crash      (crash),
    .hit_idx    (hit_idx),
    .done       (done),
    .overrun    (overrun)
  );

  // Slot table with a 1-cycle read latency.
  logic       m_v [4];
  logic [9:0] m_x [4];
  logic [9:0] m_y [4];
  logic [9:0] m_w [4];
  logic [9:0] m_h [4];

  always @(posedge clk) begin
    obs_valid <= m_v[obs_rd_idx];
    obs_x     <= m_x[obs_rd_idx];
    obs_y     <= m_y[obs_rd_idx];
    obs_w     <= m_w[obs_rd_idx];
    obs_h     <= m_h[obs_rd_idx];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int ovr_cnt  = 0;

  typedef struct {
    logic       crash;
    logic [1:0] idx;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes one expectation per done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = exp_q.pop_front();
          check("scan_crash",   {31'd0, crash},   {31'd0, e.crash});
          check("scan_hit_idx", {30'd0, hit_idx}, {30'd0, e.idx});
          check("done_latency", cyc,              e.cyc);
        end
      end
    end
  end

  task automatic set_trex(input int x, input int y, input int w, input int h);
    trex_x = 10'(x); trex_y = 10'(y); trex_w = 10'(w); trex_h = 10'(h);
  endtask

  task automatic set_slot(input int s, input bit v, input int x, input int y,
                          input int w, input int h);
    m_v[s] = v; m_x[s] = 10'(x); m_y[s] = 10'(y); m_w[s] = 10'(w); m_h[s] = 10'(h);
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 0, 0, 0, 0);
  endtask

  // Called on a negedge; update is sampled at the next posedge (E0) and
  // done is expected at the negedge after E0+5.
  task automatic start_scan(input bit push, input logic c, input logic [1:0] idx);
    exp_t e;
    if (push) begin
      e.crash = c;
      e.idx   = idx;
      e.cyc   = cyc + 6;
      exp_q.push_back(e);
    end
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int o0;
    bit rd_moved;

    rst = 1'b1; update = 1'b0; enable = 1'b1; restart = 1'b0;
    set_trex(50, 93, 44, 47);
    clear_slots();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_crash",   {31'd0, crash},      0);
    check("rst_hit_idx", {30'd0, hit_idx},    0);
    check("rst_done",    {31'd0, done},       0);
    check("rst_overrun", {31'd0, overrun},    0);
    check("rst_rd_idx",  {30'd0, obs_rd_idx}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: box (54,97,36,39) hits slot 2; slot 0 overlaps but is not valid.
    //    Trex moves away mid-scan, which must be ignored.
    set_slot(0, 1'b0, 60, 100, 10, 10);
    set_slot(2, 1'b1, 70, 100, 17, 35);
    start_scan(1'b1, 1'b1, 2'd2);
    set_trex(500, 500, 44, 47);
    wait_done("t1");
    set_trex(50, 93, 44, 47);

    // 2: touching edges on right (x=90), left (x+w=54) and bottom (y=136).
    pulse_restart();
    check("restart_crash",   {31'd0, crash},   0);
    check("restart_hit_idx", {30'd0, hit_idx}, 0);
    clear_slots();
    set_slot(0, 1'b1, 90, 100, 10, 35);
    set_slot(1, 1'b1, 44, 100, 10, 35);
    set_slot(2, 1'b1, 60, 136, 10, 10);
    d0 = done_cnt;
    start_scan(1'b1, 1'b0, 2'd0);
    wait_done("t2");
    repeat (3) @(negedge clk);
    check("t2_single_done", done_cnt - d0, 1);

    // 3: slots 1 and 3 overlap -> first wins; then only slot 3 -> frozen at 1.
    clear_slots();
    set_slot(1, 1'b1, 60, 100, 10, 10);
    set_slot(3, 1'b1, 80, 110, 5, 5);
    start_scan(1'b1, 1'b1, 2'd1);
    wait_done("t3a");
    set_slot(1, 1'b0, 60, 100, 10, 10);
    start_scan(1'b1, 1'b1, 2'd1);
    wait_done("t3b");

    // Reset in the middle of a scan: full reset values, no done.
    d0 = done_cnt;
    start_scan(1'b0, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_crash",   {31'd0, crash},      0);
    check("midrst_hit_idx", {30'd0, hit_idx},    0);
    check("midrst_done",    {31'd0, done},       0);
    check("midrst_rd_idx",  {30'd0, obs_rd_idx}, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);

    // 4: second update 2 cycles into the scan -> one overrun, one done.
    clear_slots();
    set_slot(2, 1'b1, 70, 100, 17, 35);
    d0 = done_cnt;
    o0 = ovr_cnt;
    start_scan(1'b1, 1'b1, 2'd2);
    repeat (2) @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    wait_done("t4");
    repeat (4) @(negedge clk);
    check("t4_overrun_pulses", ovr_cnt - o0, 1);
    check("t4_single_done",    done_cnt - d0, 1);

    // 5: restart on the same edge as the DRAIN compare that would hit slot 3.
    pulse_restart();
    clear_slots();
    set_slot(3, 1'b1, 80, 110, 5, 5);
    d0 = done_cnt;
    start_scan(1'b0, 1'b0, 2'd0);
    repeat (4) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("t5_crash",   {31'd0, crash},   0);
    check("t5_hit_idx", {30'd0, hit_idx}, 0);
    repeat (6) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    start_scan(1'b1, 1'b1, 2'd3);
    wait_done("t5_rescan");

    // 6: trex width 8 collapses to zero -> never hits.
    pulse_restart();
    clear_slots();
    set_trex(50, 93, 8, 47);
    set_slot(2, 1'b1, 40, 90, 40, 60);
    start_scan(1'b1, 1'b0, 2'd0);
    wait_done("t6");

    // enable low: update starts nothing.
    enable = 1'b0;
    d0 = done_cnt;
    o0 = ovr_cnt;
    rd_moved = 1'b0;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (obs_rd_idx !== 2'd0) rd_moved = 1'b1;
      @(negedge clk);
    end
    check("dis_rd_idx_moved", {31'd0, rd_moved}, 0);
    check("dis_no_done",      done_cnt - d0, 0);
    check("dis_no_overrun",   ovr_cnt - o0,  0);
    enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_trex_collision
